// File: rtl/kb_pkg.sv
// Shared scan-code, ASCII and FSM definitions for the keyboard ASCII stream.
package kb_pkg;

  // PS/2 set-2 prefix and special make codes
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  // ASCII values
  localparam logic [6:0] ASCII_NUL      = 7'h00;
  localparam logic [6:0] ASCII_BS       = 7'h08;
  localparam logic [6:0] ASCII_CR       = 7'h0D;
  localparam logic [6:0] ASCII_SPACE    = 7'h20;
  localparam logic [6:0] ASCII_CASE_BIT = 7'h20;

  // Prefix tracking states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kb_state_e;

  // Translate a make code to ASCII; returns ASCII_NUL when the code has no mapping.
  function automatic logic [6:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       shift,
                                               input logic       caps);
    logic [6:0] lc;
    logic [6:0] c;
    lc = ASCII_NUL;
    c  = ASCII_NUL;
    case (code)
      8'h1C: lc = 7'h61; 8'h32: lc = 7'h62; 8'h21: lc = 7'h63; 8'h23: lc = 7'h64;
      8'h24: lc = 7'h65; 8'h2B: lc = 7'h66; 8'h34: lc = 7'h67; 8'h33: lc = 7'h68;
      8'h43: lc = 7'h69; 8'h3B: lc = 7'h6A; 8'h42: lc = 7'h6B; 8'h4B: lc = 7'h6C;
      8'h3A: lc = 7'h6D; 8'h31: lc = 7'h6E; 8'h44: lc = 7'h6F; 8'h4D: lc = 7'h70;
      8'h15: lc = 7'h71; 8'h2D: lc = 7'h72; 8'h1B: lc = 7'h73; 8'h2C: lc = 7'h74;
      8'h3C: lc = 7'h75; 8'h2A: lc = 7'h76; 8'h1D: lc = 7'h77; 8'h22: lc = 7'h78;
      8'h35: lc = 7'h79; 8'h1A: lc = 7'h7A;
      default: lc = ASCII_NUL;
    endcase
    if (lc != ASCII_NUL) begin
      c = (shift ^ caps) ? (lc - ASCII_CASE_BIT) : lc;
    end else begin
      case (code)
        8'h45:    c = shift ? 7'h29 : 7'h30;
        8'h16:    c = shift ? 7'h21 : 7'h31;
        8'h1E:    c = shift ? 7'h40 : 7'h32;
        8'h26:    c = shift ? 7'h23 : 7'h33;
        8'h25:    c = shift ? 7'h24 : 7'h34;
        8'h2E:    c = shift ? 7'h25 : 7'h35;
        8'h36:    c = shift ? 7'h5E : 7'h36;
        8'h3D:    c = shift ? 7'h26 : 7'h37;
        8'h3E:    c = shift ? 7'h2A : 7'h38;
        8'h46:    c = shift ? 7'h28 : 7'h39;
        SC_SPACE: c = ASCII_SPACE;
        SC_ENTER: c = ASCII_CR;
        SC_BKSP:  c = ASCII_BS;
        default:  c = ASCII_NUL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/kb_char_fifo.sv
// Generic first-word fall-through FIFO with full/empty/level status.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module kb_char_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Qualify requests and advance pointers/occupancy
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/kb_ascii_stream.sv
// PS/2 set-2 scan-code decoder producing a buffered ASCII character stream
// with shift/caps-lock tracking and a valid/ready output handshake.
module kb_ascii_stream
  import kb_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 8,
  parameter bit         ENABLE_CAPS  = 1'b1,
  parameter logic [6:0] DEFAULT_CHAR = 7'h00
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_ready,
  output logic [6:0]                    char_out,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic                          shift_active,
  output logic                          caps_active,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  kb_state_e  state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       overflow_q, overflow_d;
  logic       produce;
  logic [6:0] char_val;
  logic [6:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop_fire;

  assign char_valid   = !fifo_empty;
  assign char_out     = fifo_empty ? ASCII_NUL : fifo_rdata;
  assign pop_fire     = char_valid && char_ready;
  assign shift_active = lshift_q | rshift_q;
  assign caps_active  = caps_q;
  assign overflow     = overflow_q;

  // Prefix tracking, modifier updates and character generation for one byte;
  // characters use the modifier state held before this byte.
  always_comb begin
    state_d  = state_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    caps_d   = caps_q;
    produce  = 1'b0;
    char_val = ASCII_NUL;
    if (scan_ready) begin
      case (state_q)
        IDLE: begin
          if (scan_code == SC_E0) begin
            state_d = EXT;
          end else if (scan_code == SC_F0) begin
            state_d = BRK;
          end else if (scan_code == SC_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (scan_code == SC_RSHIFT) begin
            rshift_d = 1'b1;
          end else if (scan_code == SC_CAPS) begin
            if (ENABLE_CAPS) caps_d = ~caps_q;
          end else begin
            char_val = scan_to_ascii(scan_code, lshift_q | rshift_q, caps_q);
            if (char_val == ASCII_NUL) char_val = DEFAULT_CHAR;
            produce = (char_val != ASCII_NUL);
          end
        end
        EXT: begin
          state_d = (scan_code == SC_F0) ? EXT_BRK : IDLE;
        end
        BRK: begin
          if (scan_code == SC_LSHIFT) lshift_d = 1'b0;
          if (scan_code == SC_RSHIFT) rshift_d = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sticky overflow when a produced character finds no room; clear has priority
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow)                         overflow_d = 1'b0;
    else if (produce && fifo_full && !pop_fire) overflow_d = 1'b1;
  end

  // Decoder state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      caps_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      caps_q     <= caps_d;
      overflow_q <= overflow_d;
    end
  end

  kb_char_fifo #(
    .WIDTH (7),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (produce),
    .wdata (char_val),
    .pop   (char_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

endmodule

// File: tb/tb_kb_ascii_stream.sv
// Self-checking bench: a queue-based reference model tracks the expected
// character stream and modifier state, compared every cycle, plus directed
// scan-code sequences with hand-computed results.
module tb_kb_ascii_stream;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_ready = 1'b0;
  logic       char_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [6:0] char_out;
  logic       char_valid;
  logic       shift_active;
  logic       caps_active;
  logic       overflow;
  logic [3:0] fill_level;

  int checks = 0;
  int errors = 0;

  kb_ascii_stream #(
    .FIFO_DEPTH   (DEPTH),
    .ENABLE_CAPS  (1'b1),
    .DEFAULT_CHAR (7'h00)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .scan_code      (scan_code),
    .scan_ready     (scan_ready),
    .char_out       (char_out),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .shift_active   (shift_active),
    .caps_active    (caps_active),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .fill_level     (fill_level)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};
  string      digit_syms = ")!@#$%^&*(";

  logic [6:0] mq [$];
  bit m_lshift, m_rshift, m_caps, m_ovf, pend_ext, pend_brk;

  function automatic logic [6:0] model_char(input logic [7:0] code, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) return 7'((sh ^ cp) ? (65 + i) : (97 + i));
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) return sh ? 7'(digit_syms[i]) : 7'(48 + i);
    if (code == 8'h29) return 7'h20;
    if (code == 8'h5A) return 7'h0D;
    if (code == 8'h66) return 7'h08;
    return 7'h00;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_lshift = 0; m_rshift = 0; m_caps = 0; m_ovf = 0;
      pend_ext = 0; pend_brk = 0;
    end else begin
      bit popped;
      logic [6:0] c;
      c = 7'h00;
      popped = (mq.size() != 0) && char_ready;
      if (popped) void'(mq.pop_front());
      if (scan_ready) begin
        if (pend_ext && !pend_brk) begin
          if (scan_code == 8'hF0) pend_brk = 1; else pend_ext = 0;
        end else if (pend_brk) begin
          if (!pend_ext) begin
            if (scan_code == 8'h12) m_lshift = 0;
            if (scan_code == 8'h59) m_rshift = 0;
          end
          pend_ext = 0; pend_brk = 0;
        end else if (scan_code == 8'hE0) pend_ext = 1;
        else if (scan_code == 8'hF0) pend_brk = 1;
        else if (scan_code == 8'h12) m_lshift = 1;
        else if (scan_code == 8'h59) m_rshift = 1;
        else if (scan_code == 8'h58) m_caps = !m_caps;
        else c = model_char(scan_code, m_lshift || m_rshift, m_caps);
      end
      if (c != 7'h00) begin
        if (mq.size() < DEPTH) mq.push_back(c);
        else m_ovf = 1;
      end
      if (clear_overflow) m_ovf = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("model_char_valid", int'(char_valid), int'(mq.size() != 0));
    check("model_char_out", int'(char_out), (mq.size() != 0) ? int'(mq[0]) : 0);
    check("model_fill_level", int'(fill_level), mq.size());
    check("model_shift", int'(shift_active), int'(m_lshift || m_rshift));
    check("model_caps", int'(caps_active), int'(m_caps));
    check("model_overflow", int'(overflow), int'(m_ovf));
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_ready = 1'b1;
    @(posedge clk); #1;
    scan_ready = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [6:0] e);
    check({name, "_valid"}, int'(char_valid), 1);
    check(name, int'(char_out), int'(e));
    char_ready = 1'b1;
    @(posedge clk); #1;
    char_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill_codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    #22; resetn = 1'b1;
    @(posedge clk); #1;
    check("reset_valid", int'(char_valid), 0);
    check("reset_fill", int'(fill_level), 0);
    check("reset_char_out", int'(char_out), 0);
    check("reset_overflow", int'(overflow), 0);

    // Asynchronous reset mid-stream
    send(8'h1C); send(8'h12);
    check("pre_reset_shift", int'(shift_active), 1);
    check("pre_reset_fill", int'(fill_level), 1);
    #1 resetn = 1'b0;
    #1;
    check("async_reset_shift", int'(shift_active), 0);
    check("async_reset_valid", int'(char_valid), 0);
    check("async_reset_fill", int'(fill_level), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Case logic
    send(8'h1C);
    check("first_latency_valid", int'(char_valid), 1);
    pop_expect("lower_a", 7'h61);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    pop_expect("shift_A", 7'h41);
    pop_expect("after_release_a", 7'h61);
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    check("caps_on", int'(caps_active), 1);
    pop_expect("caps_A", 7'h41);
    send(8'h58); send(8'hF0); send(8'h58);
    check("caps_off", int'(caps_active), 0);
    send(8'h58); send(8'h12); send(8'h1C);
    pop_expect("caps_shift_a", 7'h61);
    send(8'hF0); send(8'h12); send(8'h58);
    check("restored_shift", int'(shift_active), 0);

    // Extended and break sequences
    send(8'hE0); send(8'h12); send(8'h1C);
    check("fake_shift_ignored", int'(shift_active), 0);
    pop_expect("ext_then_a", 7'h61);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_break_nopush", int'(fill_level), 0);
    send(8'hF0); send(8'h1C);
    check("break_nopush", int'(fill_level), 0);

    // Digits and controls
    send(8'h12); send(8'h16);
    pop_expect("shift_1_bang", 7'h21);
    send(8'hF0); send(8'h12); send(8'h45);
    pop_expect("digit_0", 7'h30);
    send(8'h5A);
    pop_expect("enter", 7'h0D);
    send(8'h66);
    pop_expect("backspace", 7'h08);
    send(8'h29);
    pop_expect("space", 7'h20);

    // Full FIFO with drop
    for (int i = 0; i < 9; i++) send(8'h1C);
    check("full_fill", int'(fill_level), 8);
    check("full_overflow", int'(overflow), 1);
    for (int i = 0; i < 8; i++) pop_expect("full_pop_a", 7'h61);
    check("drained_valid", int'(char_valid), 0);
    check("overflow_sticky", int'(overflow), 1);
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    check("overflow_cleared", int'(overflow), 0);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 8; i++) send(fill_codes[i]);
    check("sim_full", int'(fill_level), 8);
    char_ready = 1'b1;
    send(fill_codes[8]);
    char_ready = 1'b0;
    check("sim_fill_kept", int'(fill_level), 8);
    check("sim_no_overflow", int'(overflow), 0);
    for (int i = 1; i < 9; i++) pop_expect("sim_order", 7'(98 + i - 1));
    check("sim_drained", int'(fill_level), 0);

    // Pop while empty has no effect
    char_ready = 1'b1;
    @(posedge clk); #1;
    char_ready = 1'b0;
    check("empty_pop_fill", int'(fill_level), 0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kb_ascii_stream.md
Name: kb_ascii_stream

Overview:
- Parametrised successor to the combinational scan-code→ASCII translator.
- Consumes PS/2 set-2 scan codes from the `keyboard` block.
- Tracks make/break prefixes, shift and caps-lock state, and emits true upper/lower-case ASCII plus shifted digit symbols.
- Characters are buffered in a FIFO with a valid/ready handshake, so the notepad/VGA writer can stall without losing keystrokes.

Parameters:
- FIFO_DEPTH, 8, number of buffered characters; power of two, 2..64.
- ENABLE_CAPS, 1, 1 = scan code 0x58 toggles caps lock; 0 = caps lock ignored.
- DEFAULT_CHAR, 7'h00, emitted value for unmapped make codes; 7'h00 means suppress (no push).

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous, active-low reset.
- scan_code  in  8  byte from `keyboard`; valid only when scan_ready=1.
- scan_ready  in  1  one-cycle strobe, one per received byte.
- char_out  out  7  ASCII at FIFO head.
- char_valid  out  1  FIFO non-empty.
- char_ready  in  1  consumer pop; a pop occurs when char_valid && char_ready.
- shift_active  out  1  left (0x12) or right (0x59) shift currently held.
- caps_active  out  1  caps-lock toggle state.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- clear_overflow  in  1  synchronous clear of overflow.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, resetn=0): FSM→IDLE; lshift, rshift, caps_active, overflow = 0; FIFO empty; char_valid=0; fill_level=0; char_out=0.
- Prefix FSM, advanced only on edges where scan_ready=1:
  - IDLE: 0xE0→EXT; 0xF0→BRK; other→process as make, stay IDLE.
  - EXT: 0xF0→EXT_BRK; other→ignore (extended make, including E0 12 fake shift), →IDLE.
  - BRK: byte is a release; 0x12 clears lshift, 0x59 clears rshift; others ignored; →IDLE.
  - EXT_BRK: any byte ignored; →IDLE.
- Make processing:
  - 0x12 / 0x59 set lshift / rshift.
  - 0x58 toggles caps_active if ENABLE_CAPS.
  - Other mapped codes produce one character. Typematic repeats are repeated make codes, so each one produces a character.
- Mapping (shift = lshift|rshift):
  - Letters: uppercase iff shift XOR caps_active; e.g. 0x1C → 'a' (0x61) / 'A' (0x41).
  - Digit row: unshifted '0'-'9'; shifted ")!@#$%^&*(" respectively.
  - 0x29 → 0x20 (space); 0x5A → 0x0D (enter); 0x66 → 0x08 (backspace).
  - Unmapped → DEFAULT_CHAR (suppressed if 0).
- Shift/caps state used for a character is the state before the current byte's update.
- Latency: char is written to the FIFO on the same edge that samples scan_ready. char_valid/char_out reflect it from the next cycle (first-word fall-through).
- FIFO:
  - Push when a character is produced and (not full, or a pop occurs on the same edge).
  - Full with no pop: character dropped, overflow set.
  - Simultaneous push+pop: fill_level unchanged, order preserved.
  - Pop when empty: no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- overflow: clear_overflow wins over a same-cycle set.
- shift_active and caps_active are registered and update on the scan_ready edge.
- A scan_ready pulse arriving while the FSM is mid-prefix is simply the next byte of that sequence. There is no timeout.

Decomposition:
- Package kb_pkg:
  - Scan-code constants (SC_E0, SC_F0, SC_LSHIFT, SC_RSHIFT, SC_CAPS, SC_ENTER, SC_BKSP, SC_SPACE).
  - ASCII constants.
  - FSM state enum (IDLE, EXT, BRK, EXT_BRK).
- Sub-module kb_char_fifo: generic synchronous FWFT FIFO, parameters WIDTH and DEPTH, exposing full/empty/level. The decode FSM and lookup stay in the top.

Test Plan:
- Reset mid-stream: send 0x12 then assert resetn=0 → shift_active=0, char_valid=0, fill_level=0 immediately (asynchronously).
- Case logic:
  - Bytes 1C → char_out=0x61.
  - 12,1C,F0,12,1C → queue 0x41, 0x61.
  - 58,F0,58,1C → 0x41.
  - 58,12,1C → 0x61.
- Extended/break: E0,12,1C → 0x61 (fake shift ignored); E0,F0,75 → nothing pushed; F0,1C → nothing pushed.
- Digits and controls: 12,16 → '!' (0x21); F0,12,45 → '0' (0x30); 5A → 0x0D; 66 → 0x08.
- Full FIFO, DEPTH=8, char_ready=0:
  - Push 9×'a' → fill_level=8, overflow=1, only 8 popped.
  - clear_overflow → overflow=0.
- Simultaneous: FIFO full, char_ready=1 on the same edge as a new make → fill_level stays 8, no overflow, FIFO order intact.
